uart_tx_feeder: RTL

- Byte FIFO plus handshake sequencer sitting directly upstream of the UART transmitter (uart_tx).
- Producers push bytes with a single-cycle write strobe.
- The block presents one byte at a time on uart_tx's level/edge handshake (data, data_valid, tx_ack), so bursts from the host/IB logic are serialised without loss until full.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo_core.sv | 83 ++++++++
 rtl/uart_tx_feeder.sv | 92 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Byte type and feeder sequencer states.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        RELEASE
    } feeder_state_t;

endpackage

// File: rtl/sync_fifo_core.sv
// Byte FIFO with registered count/full/empty flags.
// Flush overrides both the write and the pop of the same cycle.
module sync_fifo_core
    import uart_pkg::*;
#(
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  uart_byte_t            wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    output uart_byte_t            rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    uart_byte_t            mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, empty_q, overflow_q;
    logic                  do_wr, do_rd;

    assign do_wr = wr_en & ~full_q & ~flush;
    assign do_rd = rd_en & ~empty_q & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_wr && !do_rd)
                count_d = count_q + CNT_ONE;
            else if (!do_wr && do_rd)
                count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == CNT_FULL);
            empty_q    <= (count_d == '0);
            overflow_q <= wr_en & full_q & ~flush;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Serialises queued bytes onto the uart_tx data/data_valid/tx_ack handshake.
// Every byte gets a fresh rising edge of tx_data_valid.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                nrst,
    input  uart_byte_t          wr_data,
    input  logic                wr_en,
    input  logic                flush,
    output logic                full,
    output logic                empty,
    output logic [ADDR_WIDTH:0] count,
    output logic                overflow,
    output logic                busy,
    output uart_byte_t          tx_data,
    output logic                tx_data_valid,
    input  logic                tx_ack
);

    feeder_state_t state_q, state_d;
    uart_byte_t    data_q, data_d;
    logic          valid_q, valid_d;
    uart_byte_t    rd_data;
    logic          pop;

    assign pop = (state_q == IDLE) & ~empty & ~flush;

    sync_fifo_core #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .nrst     (nrst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_en    (pop),
        .flush    (flush),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    data_d  = rd_data;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (tx_ack) begin
                    valid_d = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!tx_ack) state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign tx_data       = data_q;
    assign tx_data_valid = valid_q;

endmodule
